sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Shares one SRAM-like request/response port (req/addr_ok/data_ok) between the CPU instruction-fetch requester and the data-access requester.
- Sits between the pipeline's inst/data SRAM-like interfaces and the downstream memory bridge.
- Grants requests with data priority and holds a granted request stable until it is accepted.
- Tracks outstanding transactions in an in-order source-ID FIFO so each data_ok and rdata is returned to the requester that issued it.

Parameters:
MAX_OUTSTANDING, 4, max accepted-but-unanswered transactions; power of two, 2..16
CNT_W, $clog2(MAX_OUTSTANDING)+1, width of outstanding count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
inst_req  in  1  instruction request valid
inst_wr  in  1  write (0 for fetch)
inst_size  in  2  0=byte,1=half,2=word
inst_wstrb  in  4  byte write strobes
inst_addr  in  32  address
inst_wdata  in  32  write data
inst_addr_ok  out  1  instruction request accepted this cycle
inst_data_ok  out  1  instruction response this cycle
inst_rdata  out  32  instruction read data
data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data requester; same meaning as inst_*
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response
data_rdata  out  32  data read data
mem_req  out  1  downstream request valid
mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  muxed request fields
mem_addr_ok  in  1  downstream accepted request
mem_data_ok  in  1  downstream response valid; responses return in issue order
mem_rdata  in  32  response data
outstanding  out  CNT_W  current FIFO occupancy
idle  out  1  state==IDLE and outstanding==0

Behaviour:
- States:
  - IDLE: no grant held.
  - HOLD_I: instruction request issued, not yet accepted.
  - HOLD_D: data request issued, not yet accepted.
- Reset asserted (at any time, including mid-transaction):
  - State returns to IDLE; FIFO pointers and count clear to 0.
  - mem_req, all addr_ok and data_ok outputs forced 0 while reset is high.
  - idle=1, outstanding=0.
  - In-flight responses arriving after reset release are ignored (empty FIFO rule).
- full = (outstanding==MAX_OUTSTANDING). When full, no new grant is made in IDLE and mem_req=0.
- IDLE, not full:
  - data_req=1: grant data.
  - else inst_req=1: grant inst.
  - else mem_req=0.
  - When granted: mem_req=1, fields muxed from the winner, all in the same cycle (combinational).
  - mem_addr_ok=1 in the same cycle: stay IDLE, winner's addr_ok=1.
  - mem_addr_ok=0: go to HOLD_I or HOLD_D.
- HOLD_x:
  - mem_req=1 and fields driven from the latched requester x, regardless of the other requester.
  - x's req and fields must stay stable; a requester dropping req in HOLD is a protocol violation and is not handled.
  - On mem_addr_ok: x_addr_ok=1, next state IDLE.
  - The next grant is evaluated in IDLE the following cycle. No back-to-back issue from HOLD.
- addr_ok routing: x_addr_ok = mem_req & mem_addr_ok & (current grant == x). The non-granted requester's addr_ok is 0.
- FIFO:
  - Push source bit (0=inst, 1=data) when mem_req & mem_addr_ok.
  - Pop when mem_data_ok & outstanding!=0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Response routing:
  - inst_data_ok = mem_data_ok & nonempty & head==0.
  - data_data_ok = mem_data_ok & nonempty & head==1.
  - Zero-latency combinational path.
- inst_rdata = data_rdata = mem_rdata, unconditional passthrough.
- mem_data_ok while FIFO empty: ignored; neither data_ok asserts and count stays 0.
- A push in the same cycle as a data_ok is never routed to that data_ok; the head is read before the push.
- Write responses also occupy FIFO entries and return data_ok.
- Latency: arbiter adds 0 cycles on the request and response paths when the request is accepted in IDLE.

Test Plan:
- Reset mid-HOLD_D with outstanding=3 → next cycle after release: idle=1, outstanding=0, mem_req=0; a stray mem_data_ok produces no inst/data data_ok.
- inst_req and data_req both high in IDLE, mem_addr_ok=1 → data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr. Next cycle inst is granted; FIFO holds {1,0}.
- Data granted, mem_addr_ok held 0 for 3 cycles → mem_addr stays data_addr 0x1c000100 for 3 cycles despite inst_req=1; 4th cycle addr_ok → data_addr_ok=1.
- MAX_OUTSTANDING=4: issue 4 inst fetches with no responses → outstanding=4, mem_req=0 with inst_req=1. One mem_data_ok → inst_data_ok=1, outstanding=3, a request issues next cycle.
- Issue order inst,data,inst; responses rdata 0xA,0xB,0xC → inst gets 0xA, data gets 0xB, inst gets 0xC.
- Same-cycle accept and mem_data_ok at outstanding=2 → outstanding stays 2; data_ok goes to the old head.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for an SRAM-like port: data-priority grant, hold-until-accept,
// and an in-order source FIFO that routes each response back to its issuer.
module sram_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [31:0]       inst_addr,
    input  logic [31:0]       inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata,

    output logic [CNT_W-1:0]  outstanding,
    output logic              idle
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_t;

    state_t                     state;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [MAX_OUTSTANDING-1:0] src_q;
    logic [CNT_W-1:0]           count;

    logic full;
    logic nonempty;
    logic grant_valid;
    logic grant_data;
    logic accept;
    logic pop;
    logic head;

    assign full     = (count == CNT_W'(MAX_OUTSTANDING));
    assign nonempty = (count != '0);
    assign head     = src_q[rd_ptr];

    // Grant selection: a held grant wins outright; otherwise data beats inst when not full.
    always_comb begin
        grant_valid = 1'b0;
        grant_data  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!full) begin
                    if (data_req) begin
                        grant_valid = 1'b1;
                        grant_data  = 1'b1;
                    end else if (inst_req) begin
                        grant_valid = 1'b1;
                    end
                end
            end
            HOLD_I: grant_valid = 1'b1;
            HOLD_D: begin
                grant_valid = 1'b1;
                grant_data  = 1'b1;
            end
            default: ;
        endcase
    end

    // Request path is zero-latency; reset forces every handshake low.
    assign mem_req   = grant_valid & ~reset;
    assign mem_wr    = grant_data ? data_wr    : inst_wr;
    assign mem_size  = grant_data ? data_size  : inst_size;
    assign mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
    assign mem_addr  = grant_data ? data_addr  : inst_addr;
    assign mem_wdata = grant_data ? data_wdata : inst_wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & ~grant_data;
    assign data_addr_ok = accept &  grant_data;

    // Responses follow FIFO head; stray responses with nothing outstanding are dropped.
    assign pop          = mem_data_ok & nonempty & ~reset;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop &  head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign outstanding = count;
    assign idle        = (state == IDLE) && !nonempty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid && !mem_addr_ok) begin
                        state <= grant_data ? HOLD_D : HOLD_I;
                    end
                end
                HOLD_I, HOLD_D: begin
                    if (mem_addr_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Source-ID FIFO: head is read combinationally before any same-cycle push lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            src_q  <= '0;
        end else begin
            if (accept) begin
                src_q[wr_ptr] <= grant_data;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule
